// File: rtl/pp_pipeline_accel_ap_chain_launcher_if.sv
// Parent, child and return-FIFO handshake bundle of the ap_chain launcher.
// slave = launcher side, master = environment (parent, child and consumer) side.
interface pp_pipeline_accel_ap_chain_launcher_if #(
  parameter int DATA_WIDTH = 19,
  parameter int CNT_WIDTH  = 16
);
  logic                  ap_start;
  logic                  ap_done;
  logic                  ap_continue;
  logic                  ap_idle;
  logic                  ap_ready;
  logic [CNT_WIDTH-1:0]  num_runs;
  logic                  child_ap_start;
  logic                  child_ap_ready;
  logic                  child_ap_done;
  logic                  child_ap_continue;
  logic [DATA_WIDTH-1:0] child_ap_return;
  logic [DATA_WIDTH-1:0] ret_dout;
  logic                  ret_empty_n;
  logic                  ret_read;

  modport slave (
    input  ap_start, ap_continue, num_runs,
    input  child_ap_ready, child_ap_done, child_ap_return,
    input  ret_read,
    output ap_done, ap_idle, ap_ready,
    output child_ap_start, child_ap_continue,
    output ret_dout, ret_empty_n
  );

  modport master (
    output ap_start, ap_continue, num_runs,
    output child_ap_ready, child_ap_done, child_ap_return,
    output ret_read,
    input  ap_done, ap_idle, ap_ready,
    input  child_ap_start, child_ap_continue,
    input  ret_dout, ret_empty_n
  );
endinterface

// File: rtl/pp_pipeline_accel_ap_chain_launcher.sv
// Launches a child process num_runs times over ap_ctrl_hs and queues its returns in a FWFT FIFO.
// Optional macro PP_LAUNCH_PERF_EN adds a saturating RUN-dwell counter on output perf_cycles.
module pp_pipeline_accel_ap_chain_launcher #(
  parameter int DATA_WIDTH = 19,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic ap_clk,
  input  logic ap_rst,
`ifdef PP_LAUNCH_PERF_EN
  output logic [31:0] perf_cycles,
`endif
  pp_pipeline_accel_ap_chain_launcher_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            r_state;
  logic [CNT_WIDTH-1:0]  r_runs;
  logic [CNT_WIDTH-1:0]  r_starts;
  logic [CNT_WIDTH-1:0]  r_dones;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W:0]        r_count;

  logic w_accept;
  logic w_start;
  logic w_cont;
  logic w_launch;
  logic w_complete;
  logic w_last_done;
  logic w_pop;
  logic w_empty_n;

  // Continue is gated on the registered count, so a full FIFO back-pressures the child's done.
  assign w_empty_n   = (r_count != '0);
  assign w_accept    = (r_state == S_IDLE) && bus.ap_start;
  assign w_start     = (r_state == S_RUN) && (r_starts < r_runs);
  assign w_cont      = (r_state == S_RUN) && (r_dones < r_runs) && (r_count < FULL_CNT);
  assign w_launch    = w_start && bus.child_ap_ready;
  assign w_complete  = w_cont && bus.child_ap_done;
  assign w_last_done = w_complete && (r_dones == (r_runs - CNT_WIDTH'(1)));
  assign w_pop       = bus.ret_read && w_empty_n;

  assign bus.ap_ready          = w_accept;
  assign bus.ap_idle           = (r_state == S_IDLE) && !bus.ap_start;
  assign bus.ap_done           = (r_state == S_DONE);
  assign bus.child_ap_start    = w_start;
  assign bus.child_ap_continue = w_cont;
  assign bus.ret_empty_n       = w_empty_n;
  assign bus.ret_dout          = w_empty_n ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state  <= S_IDLE;
      r_runs   <= '0;
      r_starts <= '0;
      r_dones  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.ap_start) begin
            r_runs   <= bus.num_runs;
            r_starts <= '0;
            r_dones  <= '0;
            r_state  <= (bus.num_runs == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_launch)    r_starts <= r_starts + CNT_WIDTH'(1);
          if (w_complete)  r_dones  <= r_dones + CNT_WIDTH'(1);
          if (w_last_done) r_state  <= S_DONE;
        end
        S_DONE: begin
          // A start seen together with continue is only accepted once back in IDLE.
          if (bus.ap_continue) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_complete) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)      r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_complete, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; ret_dout is masked to zero while empty.
  always_ff @(posedge ap_clk) begin
    if (w_complete) r_mem[r_wr_ptr] <= bus.child_ap_return;
  end

`ifdef PP_LAUNCH_PERF_EN
  logic [31:0] r_perf;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_perf <= '0;
    end else if (w_accept && (bus.num_runs != '0)) begin
      r_perf <= '0;
    end else if (r_state == S_RUN) begin
      r_perf <= sat_inc32(r_perf);
    end
  end

  assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_pp_pipeline_accel_ap_chain_launcher.sv
// Bench for the ap_chain launcher: control-vector table, directed corner sequences and
// randomized batches against a transaction-level model of parent, child and return FIFO.
module tb_pp_pipeline_accel_ap_chain_launcher;
  localparam int DW    = 19;
  localparam int DEPTH = 2;
  localparam int CW    = 16;
  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pp_pipeline_accel_ap_chain_launcher_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
`ifdef PP_LAUNCH_PERF_EN
  logic [31:0] perf_cycles;
`endif

  pp_pipeline_accel_ap_chain_launcher #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .ap_clk(clk),
    .ap_rst(rst),
`ifdef PP_LAUNCH_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .bus(bus)
  );

  typedef struct {
    int          due;
    logic [DW-1:0] ret;
  } job_t;

  typedef struct {
    logic          start;
    logic          cont;
    logic [CW-1:0] n;
    logic          exp_ready;
    logic          exp_idle;
    logic          exp_done;
  } vec_t;

  int n_pass = 0;
  int n_checks = 0;

  // Model: batch phase, observed launch/completion counts, child job list, expected FIFO contents
  int ph = P_IDLE;
  int m_runs = 0, m_launched = 0, m_completed = 0;
  int cyc = 0, wait_cnt = 0, ch_R = 0, ch_L = 1, run_cycles = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] got[$];
  logic [DW-1:0] ret_src[$];
  job_t jobs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic settle();
    bus.child_ap_ready = bus.child_ap_start && (wait_cnt >= ch_R);
    if (jobs.size() > 0 && jobs[0].due <= cyc) begin
      bus.child_ap_done   = 1'b1;
      bus.child_ap_return = jobs[0].ret;
    end else begin
      bus.child_ap_done   = 1'b0;
      bus.child_ap_return = DW'($urandom);
    end
    #1;
    chk("ap_ready",   bus.ap_ready, (ph == P_IDLE) && bus.ap_start);
    chk("ap_idle",    bus.ap_idle,  (ph == P_IDLE) && !bus.ap_start);
    chk("ap_done",    bus.ap_done,  ph == P_DONE);
    chk("child_start", bus.child_ap_start, (ph == P_RUN) && (m_launched < m_runs));
    chk("child_cont", bus.child_ap_continue,
        (ph == P_RUN) && (m_completed < m_runs) && (q.size() < DEPTH));
    chk("ret_empty_n", bus.ret_empty_n, q.size() != 0);
    if (q.size() != 0) chk("ret_dout", bus.ret_dout, q[0]);
    else               chk("ret_dout_empty", bus.ret_dout, 0);
  endtask

  task automatic advance();
    logic l, c, p, cs, st, co, rs;
    logic [DW-1:0] d;
    logic [CW-1:0] n;
    job_t j;
    cs = bus.child_ap_start;
    l  = cs && bus.child_ap_ready;
    c  = bus.child_ap_done && bus.child_ap_continue;
    p  = bus.ret_read && (q.size() != 0);
    d  = bus.ret_dout;
    st = bus.ap_start;
    co = bus.ap_continue;
    n  = bus.num_runs;
    rs = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (rs) begin
      ph = P_IDLE; m_runs = 0; m_launched = 0; m_completed = 0;
      q.delete(); jobs.delete(); wait_cnt = 0;
    end else begin
      if (p) begin
        got.push_back(d);
        void'(q.pop_front());
      end
      if (c && jobs.size() > 0) begin
        q.push_back(jobs[0].ret);
        void'(jobs.pop_front());
        m_completed++;
      end
      if (l) begin
        j.due = cyc - 1 + ch_L;
        j.ret = (ret_src.size() != 0) ? ret_src.pop_front() : DW'($urandom);
        jobs.push_back(j);
        m_launched++;
        wait_cnt = 0;
      end else if (cs) begin
        wait_cnt++;
      end
      if (ph == P_RUN) run_cycles++;
      case (ph)
        P_IDLE: if (st) begin
          m_runs = int'(n); m_launched = 0; m_completed = 0;
          ph = (n == 0) ? P_DONE : P_RUN;
          if (n != 0) run_cycles = 0;
        end
        P_RUN:  if (m_completed == m_runs) ph = P_DONE;
        P_DONE: if (co) ph = P_IDLE;
        default: ph = P_IDLE;
      endcase
    end
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic start_batch(input int n);
    bus.num_runs = CW'(n);
    bus.ap_start = 1'b1;
    settle();
    chk("start_ready_pulse", bus.ap_ready, 1);
    advance();
    bus.ap_start = 1'b0;
  endtask

  task automatic run_until_done(input int rmode);
    int k = 0;
    while (ph != P_DONE && k < 3000) begin
      bus.ret_read = (rmode == 2) ? 1'($urandom_range(0, 1)) : rmode[0];
      step();
      k++;
    end
    chk("batch_reaches_done", ph == P_DONE, 1);
    chk("launch_count", m_launched, m_runs);
    chk("completion_count", m_completed, m_runs);
  endtask

  task automatic finish_batch(input int hold);
    int k = 0;
    repeat (hold) step();
    bus.ap_continue = 1'b1;
    step();
    bus.ap_continue = 1'b0;
    bus.ret_read = 1'b1;
    while (q.size() != 0 && k < 50) begin
      step();
      k++;
    end
    bus.ret_read = 1'b0;
    step();
    chk("drained_idle", ph == P_IDLE && q.size() == 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[10];
    logic [DW-1:0] exp_vals[$];
    int k;
    int n;

    // ap_start / ap_continue control vectors, all with num_runs = 0
    tbl[0] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 16'd0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 16'd0, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0};

    bus.ap_start = 1'b0; bus.ap_continue = 1'b0; bus.num_runs = '0;
    bus.child_ap_ready = 1'b0; bus.child_ap_done = 1'b0; bus.child_ap_return = '0;
    bus.ret_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    settle();
    chk("rst_idle", bus.ap_idle, 1);
    chk("rst_done", bus.ap_done, 0);
    chk("rst_ready", bus.ap_ready, 0);
    chk("rst_child_start", bus.child_ap_start, 0);
    chk("rst_child_cont", bus.child_ap_continue, 0);
    chk("rst_empty_n", bus.ret_empty_n, 0);
    chk("rst_dout", bus.ret_dout, 0);
    advance();

    for (int i = 0; i < 10; i++) begin
      bus.ap_start = tbl[i].start;
      bus.ap_continue = tbl[i].cont;
      bus.num_runs = tbl[i].n;
      settle();
      chk($sformatf("vec%0d_ready", i), bus.ap_ready, tbl[i].exp_ready);
      chk($sformatf("vec%0d_idle", i), bus.ap_idle, tbl[i].exp_idle);
      chk($sformatf("vec%0d_done", i), bus.ap_done, tbl[i].exp_done);
      chk($sformatf("vec%0d_child_start", i), bus.child_ap_start, 0);
      advance();
    end
    bus.ap_start = 1'b0; bus.ap_continue = 1'b0;

    // Three launches, 1-cycle child latency, consumer always reading
    got.delete();
    ch_R = 0; ch_L = 1;
    ret_src = '{19'h00010, 19'h00020, 19'h00030};
    exp_vals = '{19'h00010, 19'h00020, 19'h00030};
    start_batch(3);
    run_until_done(1);
    finish_batch(3);
    chk("t1_pop_count", got.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < got.size()) chk($sformatf("t1_pop%0d", i), got[i], exp_vals[i]);

    // Full FIFO back-pressures the child's done until one entry is popped
    got.delete();
    ret_src = '{19'h00111, 19'h00222, 19'h00333, 19'h00444};
    exp_vals = '{19'h00111, 19'h00222, 19'h00333, 19'h00444};
    start_batch(4);
    bus.ret_read = 1'b0;
    k = 0;
    while (q.size() < DEPTH && k < 50) begin step(); k++; end
    repeat (3) step();
    settle();
    chk("t3_cont_blocked", bus.child_ap_continue, 0);
    chk("t3_done_held", bus.child_ap_done, 1);
    chk("t3_full_empty_n", bus.ret_empty_n, 1);
    advance();
    bus.ret_read = 1'b1;
    step();
    bus.ret_read = 1'b0;
    settle();
    chk("t3_cont_back", bus.child_ap_continue, 1);
    advance();
    run_until_done(1);
    finish_batch(0);
    chk("t3_pop_count", got.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) chk($sformatf("t3_pop%0d", i), got[i], exp_vals[i]);

    // Slow child ready: start stays high while waiting, no duplicate launches or pushes
    got.delete();
    ch_R = 5; ch_L = 2;
    start_batch(3);
    run_until_done(1);
    finish_batch(1);
    chk("t4_pop_count", got.size(), 3);

    // Reset mid-batch with two of five done and one result still queued
    ch_R = 0; ch_L = 1;
    start_batch(5);
    bus.ret_read = 1'b0;
    k = 0;
    while (m_completed < 2 && k < 50) begin step(); k++; end
    bus.ret_read = 1'b1;
    step();
    bus.ret_read = 1'b0;
    chk("t5_pre_q", q.size(), 1);
    chk("t5_pre_done_cnt", m_completed, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    chk("t5_idle", bus.ap_idle, 1);
    chk("t5_empty_n", bus.ret_empty_n, 0);
    chk("t5_dout", bus.ret_dout, 0);
    chk("t5_done", bus.ap_done, 0);
    chk("t5_child_start", bus.child_ap_start, 0);
    chk("t5_child_cont", bus.child_ap_continue, 0);
    advance();
    step();

`ifdef PP_LAUNCH_PERF_EN
    ch_R = 0; ch_L = 4;
    start_batch(2);
    run_until_done(1);
    chk("perf_at_done", perf_cycles, run_cycles);
    repeat (3) step();
    chk("perf_held_done", perf_cycles, run_cycles);
    finish_batch(0);
    chk("perf_held_idle", perf_cycles, run_cycles);
`endif

    // Randomized batches: random sizes, child latencies, read pattern and continue delay
    for (int b = 0; b < 10; b++) begin
      got.delete();
      n = $urandom_range(1, 6);
      ch_R = $urandom_range(0, 3);
      ch_L = $urandom_range(1, 5);
      start_batch(n);
      run_until_done(2);
      finish_batch($urandom_range(0, 3));
      chk($sformatf("rand%0d_pops", b), got.size() >= 1, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
